clk_rst_sequencer: RTL

Central clock-enable and reset controller for the GEMM accelerator subsystem.
- Generates a programmable-ratio clock-enable strobe for the slow datapath. It does not generate a derived clock, which keeps the design in a single clock domain.
- Releases a staged set of per-domain resets (for example: systolic array, buffers, RISC-V interface) after a fixed hold period.
- Accepts divider reconfiguration and soft-reset requests from the CPU-side control logic.

---
 rtl/clk_rst_pkg.sv | 22 ++
 rtl/clk_en_gen.sv | 62 ++++++
 rtl/clk_rst_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/clk_rst_pkg.sv
// Shared types and default constants for the GEMM subsystem clock-enable / reset sequencer.
package clk_rst_pkg;

   typedef enum logic [1:0] {
      SYNC    = 2'd0,
      HOLD    = 2'd1,
      RELEASE = 2'd2,
      RUN     = 2'd3
   } seq_state_e;

   localparam int DEF_NUM_DOM     = 3;
   localparam int DEF_HOLD_CYCLES = 12;
   localparam int DEF_STAGE_GAP   = 4;
   localparam int DEF_DIV_W       = 4;
   localparam int DEF_DIV         = 4;

   // Width of a counter that must reach n-1; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clk_en_gen.sv
// Programmable-ratio clock-enable strobe with a shadowed divide ratio that only
// takes effect on a period boundary.
module clk_en_gen
   import clk_rst_pkg::*;
#(
   parameter int DIV_W       = DEF_DIV_W,
   parameter int DEFAULT_DIV = DEF_DIV
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             cfg_load,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             clk_en,
   output logic             pending
);

   logic             active_q, active_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_reg_q, div_reg_d;
   logic [DIV_W-1:0] shadow_q, shadow_d;
   logic             pending_q, pending_d;
   logic             clk_en_q, clk_en_d;
   logic             wrap;

   // run describes the coming cycle, so every flop here holds that cycle's value.
   always_comb begin
      wrap      = clk_en_q;
      div_reg_d = (wrap && pending_q) ? shadow_q : div_reg_q;
      shadow_d  = cfg_load ? cfg_div : shadow_q;
      pending_d = cfg_load | (pending_q & ~wrap);
      active_d  = run;
      if (!run || !active_q || wrap) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + DIV_W'(1);
      end
      clk_en_d = run && ((div_reg_d <= DIV_W'(1)) || (cnt_d == div_reg_d - DIV_W'(1)));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         active_q  <= 1'b0;
         cnt_q     <= '0;
         div_reg_q <= DIV_W'(DEFAULT_DIV);
         shadow_q  <= '0;
         pending_q <= 1'b0;
         clk_en_q  <= 1'b0;
      end else begin
         active_q  <= active_d;
         cnt_q     <= cnt_d;
         div_reg_q <= div_reg_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         clk_en_q  <= clk_en_d;
      end
   end

   assign clk_en  = clk_en_q;
   assign pending = pending_q;

endmodule

// File: rtl/clk_rst_sequencer.sv
// Central clock-enable and staged per-domain reset controller; single clock domain,
// with soft-reset re-sequencing and a handshaked divider update.
module clk_rst_sequencer
   import clk_rst_pkg::*;
#(
   parameter int NUM_DOM     = DEF_NUM_DOM,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int STAGE_GAP   = DEF_STAGE_GAP,
   parameter int DIV_W       = DEF_DIV_W,
   parameter int DEFAULT_DIV = DEF_DIV
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_valid,
   input  logic [DIV_W-1:0]   cfg_div,
   output logic               cfg_ready,
   input  logic               soft_rst_req,
   output logic               clk_en,
   output logic [NUM_DOM-1:0] dom_rst_n,
   output logic               seq_done
);

   localparam int HOLD_W = cnt_w(HOLD_CYCLES);
   localparam int GAP_W  = cnt_w(STAGE_GAP);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);

   seq_state_e         state_q, state_d;
   logic               rst_meta_q;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [NUM_DOM-1:0] dom_q, dom_d;
   logic               done_q, done_d;
   logic               pending;
   logic               cfg_load;
   logic               div_run;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      gap_d   = gap_q;
      dom_d   = dom_q;
      done_d  = done_q;
      case (state_q)
         // rst_meta_q is the first synchroniser stage; the state register is the second.
         SYNC: begin
            if (rst_meta_q) begin
               state_d = HOLD;
               hold_d  = '0;
            end
         end
         HOLD: begin
            if (hold_q == HOLD_LAST) begin
               dom_d   = NUM_DOM'(1);
               gap_d   = '0;
               state_d = (&dom_d) ? RUN : RELEASE;
               done_d  = &dom_d;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         RELEASE: begin
            if (gap_q == GAP_LAST) begin
               dom_d = NUM_DOM'({dom_q, 1'b1});
               gap_d = '0;
               if (&dom_d) begin
                  state_d = RUN;
                  done_d  = 1'b1;
               end
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         RUN: begin
            if (soft_rst_req) begin
               state_d = HOLD;
               hold_d  = '0;
               dom_d   = '0;
               done_d  = 1'b0;
            end
         end
         default: begin
            state_d = SYNC;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_meta_q <= 1'b0;
         state_q    <= SYNC;
         hold_q     <= '0;
         gap_q      <= '0;
         dom_q      <= '0;
         done_q     <= 1'b0;
      end else begin
         rst_meta_q <= 1'b1;
         state_q    <= state_d;
         hold_q     <= hold_d;
         gap_q      <= gap_d;
         dom_q      <= dom_d;
         done_q     <= done_d;
      end
   end

   assign cfg_ready = (state_q == RUN) && !pending;
   assign cfg_load  = cfg_valid && cfg_ready;
   // True whenever the next cycle is outside SYNC; avoids a path from soft_rst_req.
   assign div_run   = (state_q != SYNC) || rst_meta_q;

   clk_en_gen #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) u_clk_en_gen (
      .clk      (clk),
      .rst      (rst),
      .run      (div_run),
      .cfg_load (cfg_load),
      .cfg_div  (cfg_div),
      .clk_en   (clk_en),
      .pending  (pending)
   );

   assign dom_rst_n = dom_q;
   assign seq_done  = done_q;

endmodule
